rotate_arbiter: RTL

ROTATE_ARBITER -- requirements
Module: rotate_arbiter

---
 rtl/rotate_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rotate_arbiter
// Purpose  : Two requesters share one 1-bit-per-cycle left-rotate datapath
//            under round-robin arbitration.
// Revision : 1.0
// ============================================================================
module rotate_arbiter #(
    parameter  int N  = 8,
    localparam int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstN,

    input  logic          req0_valid,
    input  logic [N-1:0]  req0_data,
    input  logic [RW-1:0] req0_rfactor,
    output logic          req0_ready,

    input  logic          req1_valid,
    input  logic [N-1:0]  req1_data,
    input  logic [RW-1:0] req1_rfactor,
    output logic          req1_ready,

    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          out_id,
    input  logic          out_ready,

    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [RW-1:0] C_ONE  = RW'(1);
    localparam logic [RW-1:0] C_ZERO = '0;

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_work;
    logic [RW-1:0] r_count;
    logic          r_out_id;
    logic          r_last;

    logic          w_idle;
    logic          w_any;
    logic          w_pick1;
    logic          w_grant;
    logic [N-1:0]  w_sel_data;
    logic [RW-1:0] w_sel_rfactor;
    logic [N-1:0]  w_rotated;

    // ------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on a tie the requester
    // that was not granted last wins. Grants are masked while in reset.
    // ------------------------------------------------------------------
    assign w_idle        = (r_state == ST_IDLE);
    assign w_any         = req0_valid | req1_valid;
    assign w_pick1       = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_grant       = rstN & w_idle & w_any;

    assign req0_ready    = w_grant & ~w_pick1;
    assign req1_ready    = w_grant &  w_pick1;

    assign w_sel_data    = w_pick1 ? req1_data    : req0_data;
    assign w_sel_rfactor = w_pick1 ? req1_rfactor : req0_rfactor;

    assign w_rotated     = {r_work[N-2:0], r_work[N-1]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next_state = (w_sel_rfactor == C_ZERO) ? ST_DONE : ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                if (r_count == C_ONE) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: capture on transfer, rotate one bit per ROTATE cycle.
    // Pointer resets to 1 so requester 0 wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_work   <= '0;
            r_count  <= '0;
            r_out_id <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_work   <= w_sel_data;
                        r_count  <= w_sel_rfactor;
                        r_out_id <= w_pick1;
                        r_last   <= w_pick1;
                    end
                end
                ST_ROTATE: begin
                    r_work  <= w_rotated;
                    r_count <= r_count - C_ONE;
                end
                default: begin
                    r_work <= r_work;
                end
            endcase
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_work;
    assign out_id    = r_out_id;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
